// File: rtl/serial_negate_mc.sv
// serial_negate_mc
// Multi-lane, LSB-first, bit-serial two's-complement negator with word framing.
// Each lane either passes its word through or negates it, selected per lane at
// start-of-word. All lanes share one framing FSM and one valid strobe. Results
// appear one cycle after the input bit is accepted. The MSB result is flagged
// with y_eow and the per-lane overflow. Framing errors pulse err.
module serial_negate_mc #(
    parameter int W  = 8,
    parameter int CH = 2
) (
    input  logic          t_clk,
    input  logic          r,
    input  logic [CH-1:0] i,
    input  logic          i_vld,
    input  logic          i_sof,
    input  logic [CH-1:0] mode,
    output logic [CH-1:0] y,
    output logic          y_vld,
    output logic          y_eow,
    output logic [CH-1:0] ovf,
    output logic          err
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CH-1:0] seen_q, m_q;
    logic [CH-1:0] seen_prior, m_eff, seen_d;
    logic [CH-1:0] y_d, ovf_d;
    logic          accept, bit0, is_msb, err_d;

    logic [CH-1:0] y_p0;
    logic          vld_p0, eow_p0, err_p0;
    logic [CH-1:0] ovf_p0;

    // A bit flips once a 1 has gone by, but only in negate mode.
    function automatic logic neg_bit(input logic d, input logic m_b, input logic s);
        return d ^ (m_b & s);
    endfunction

    // Negating 100..0 gives 100..0 back: no earlier 1, and the MSB is 1.
    function automatic logic ovf_bit(input logic d, input logic m_b, input logic s);
        return m_b & ~s & d;
    endfunction

    // Control state register: FSM state and the bit counter.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A start-of-word always restarts at bit 1, and the MSB returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_vld) begin
            if (i_sof) begin
                state_d = RUN;
                cnt_d   = CNT_ONE;
            end else if (state_q == RUN) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Output/datapath logic: qualify the bit, then build the per-lane result, overflow and error.
    always_comb begin
        bit0       = i_vld & i_sof;
        accept     = i_vld & (i_sof | (state_q == RUN));
        is_msb     = i_vld & ~i_sof & (state_q == RUN) & (cnt_q == CNT_LAST);
        err_d      = i_vld & ((state_q == IDLE) ? ~i_sof : i_sof);
        seen_prior = bit0 ? '0 : seen_q;
        m_eff      = bit0 ? mode : m_q;
        y_d        = '0;
        ovf_d      = '0;
        seen_d     = '0;
        for (int k = 0; k < CH; k++) begin
            y_d[k]    = neg_bit(i[k], m_eff[k], seen_prior[k]);
            ovf_d[k]  = ovf_bit(i[k], m_eff[k], seen_prior[k]) & is_msb;
            seen_d[k] = seen_prior[k] | i[k];
        end
    end

    // Per-lane state: the seen-a-one tracker and the mode latched at start-of-word.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            seen_q <= '0;
            m_q    <= '0;
        end else begin
            if (accept) seen_q <= seen_d;
            if (bit0)   m_q    <= mode;
        end
    end

    // Stage p0: registered results. y holds its value between accepted bits.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            y_p0   <= '0;
            vld_p0 <= 1'b0;
            eow_p0 <= 1'b0;
            ovf_p0 <= '0;
            err_p0 <= 1'b0;
        end else begin
            if (accept) y_p0 <= y_d;
            vld_p0 <= accept;
            eow_p0 <= is_msb;
            ovf_p0 <= ovf_d;
            err_p0 <= err_d;
        end
    end

    assign y     = y_p0;
    assign y_vld = vld_p0;
    assign y_eow = eow_p0;
    assign ovf   = ovf_p0;
    assign err   = err_p0;

endmodule

// File: tb/tb_serial_negate_mc.sv
// Directed testbench for serial_negate_mc (W=8, CH=2).
module tb_serial_negate_mc;

    logic       t_clk = 1'b0;
    logic       r     = 1'b0;
    logic [1:0] i     = '0;
    logic       i_vld = 1'b0;
    logic       i_sof = 1'b0;
    logic [1:0] mode  = '0;
    logic [1:0] y;
    logic       y_vld;
    logic       y_eow;
    logic [1:0] ovf;
    logic       err;

    serial_negate_mc #(.W(8), .CH(2)) dut (
        .t_clk (t_clk),
        .r     (r),
        .i     (i),
        .i_vld (i_vld),
        .i_sof (i_sof),
        .mode  (mode),
        .y     (y),
        .y_vld (y_vld),
        .y_eow (y_eow),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 t_clk = ~t_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Output trackers, filled in after every clock edge.
    logic [15:0] res0, res1;
    int          bidx, vcnt, ecnt, errcnt, eow_pos, stray;
    logic [1:0]  ovf_eow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic clear();
        res0 = '0; res1 = '0;
        bidx = 0; vcnt = 0; ecnt = 0; errcnt = 0; eow_pos = 0;
        ovf_eow = '0;
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic v, input logic s, input logic [1:0] d, input logic [1:0] md);
        i_vld = v; i_sof = s; i = d; mode = md;
        @(posedge t_clk);
        #1;
        if (y_vld) begin
            if (bidx < 16) begin
                res0[bidx] = y[0];
                res1[bidx] = y[1];
            end
            bidx++;
            vcnt++;
        end
        if (y_eow) begin
            ecnt++;
            eow_pos = vcnt;
            ovf_eow = ovf;
        end else if (ovf != 2'b00) begin
            stray++;
        end
        if (err) errcnt++;
    endtask

    task automatic word(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] md);
        for (int b = 0; b < 8; b++) step(1'b1, b == 0, {a1[b], a0[b]}, md);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 2'b00, mode);
    endtask

    initial begin
        stray = 0;
        clear();

        // Reset state
        idle(2);
        chk("rst_outputs", {y, y_vld, y_eow, ovf, err}, 32'h0);
        r = 1'b1;
        idle(1);
        chk("post_rst_idle", {y, y_vld, y_eow, ovf, err}, 32'h0);

        // Negate lane 0, pass lane 1
        clear();
        word(8'h05, 8'hA3, 2'b01);
        idle(1);
        chk("neg05_y0", res0[7:0], 8'hFB);
        chk("pass_y1", res1[7:0], 8'hA3);
        chk("neg05_eow_pos", eow_pos, 8);
        chk("neg05_eow_cnt", ecnt, 1);
        chk("neg05_ovf", ovf_eow, 2'b00);
        chk("neg05_err", errcnt, 0);

        // Boundary values on lane 0
        clear(); word(8'h80, 8'h80, 2'b01); idle(1);
        chk("neg80_y0", res0[7:0], 8'h80);
        chk("neg80_ovf", ovf_eow, 2'b01);
        clear(); word(8'h00, 8'h80, 2'b11); idle(1);
        chk("neg00_y0", res0[7:0], 8'h00);
        chk("neg80_lane1_y1", res1[7:0], 8'h80);
        chk("neg00_ovf", ovf_eow, 2'b10);
        clear(); word(8'h01, 8'h00, 2'b01); idle(1);
        chk("neg01_y0", res0[7:0], 8'hFF);
        chk("neg01_ovf", ovf_eow, 2'b00);
        clear(); word(8'h7F, 8'h00, 2'b01); idle(1);
        chk("neg7F_y0", res0[7:0], 8'h81);
        chk("neg7F_ovf", ovf_eow, 2'b00);

        // Gaps within a word, then a back-to-back word
        clear();
        for (int b = 0; b < 8; b++) begin
            step(1'b1, b == 0, {1'b0, 8'h05 >> b & 8'h01 ? 1'b1 : 1'b0}, 2'b01);
            if (b == 2 || b == 5) begin
                idle(3);
                chk("gap_vld_low", y_vld, 1'b0);
                chk("gap_y_hold", y[0], (b == 2) ? 1'b0 : 1'b1);
            end
        end
        word(8'h0C, 8'h00, 2'b01);
        idle(1);
        chk("gap_word1", res0[7:0], 8'hFB);
        chk("b2b_word2", res0[15:8], 8'hF4);
        chk("gap_vld_cnt", vcnt, 16);
        chk("gap_eow_cnt", ecnt, 2);
        chk("gap_err", errcnt, 0);

        // Valid bit without sof while idle
        clear();
        step(1'b1, 1'b0, 2'b01, 2'b01);
        chk("nosof_vld", y_vld, 1'b0);
        chk("nosof_err", err, 1'b1);
        idle(1);
        chk("nosof_err_once", errcnt, 1);

        // sof in the middle of a word aborts and restarts
        clear();
        for (int b = 0; b < 4; b++) step(1'b1, b == 0, {1'b0, (b == 0 || b == 2)}, 2'b01);
        bidx = 0;
        word(8'h03, 8'h00, 2'b01);
        idle(1);
        chk("abort_err", errcnt, 1);
        chk("abort_eow_cnt", ecnt, 1);
        chk("abort_new_word", res0[7:0], 8'hFD);
        chk("abort_vld_cnt", vcnt, 12);

        // Asynchronous reset mid-word
        clear();
        for (int b = 0; b < 4; b++) step(1'b1, b == 0, {1'b0, (b == 0 || b == 2)}, 2'b01);
        i_vld = 1'b0;
        #2 r = 1'b0;
        #1;
        chk("async_rst_outputs", {y, y_vld, y_eow, ovf, err}, 32'h0);
        idle(2);
        r = 1'b1;
        clear();
        word(8'h03, 8'h00, 2'b01);
        idle(1);
        chk("post_rst_word", res0[7:0], 8'hFD);
        chk("post_rst_err", errcnt, 0);
        chk("post_rst_eow", ecnt, 1);

        // Mode change mid-word is ignored until the next sof
        clear();
        for (int b = 0; b < 8; b++)
            step(1'b1, b == 0, {1'b0, (b == 1 || b == 2)}, (b < 2) ? 2'b01 : 2'b00);
        word(8'h06, 8'h00, 2'b00);
        idle(1);
        chk("mode_latched", res0[7:0], 8'hFA);
        chk("mode_next_pass", res0[15:8], 8'h06);

        chk("ovf_outside_eow", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
